// File: rtl/counter_sweep_ctrl_if.sv
// Sweep command channel: start/end/direction offered over a valid/ready handshake.
interface counter_sweep_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_end;
  logic             cmd_up;

  modport master (
    output cmd_valid, cmd_start, cmd_end, cmd_up,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_end, cmd_up,
    output cmd_ready
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Drives an enable-less parallel-load up/down counter through one sweep per command.
//
//   state | meaning
//   INIT  | counter held in sync reset; one cycle after rst releases
//   IDLE  | counter held, waiting for a command
//   LOAD  | counter loaded with the sweep start value
//   RUN   | counter stepping toward end (holds while paused)
//   DONE  | completion pulse, counter held at end
module counter_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_sweep_ctrl_if.slave  cmd,
  input  logic                 pause,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     cnt_out,
  output logic                 cnt_rst,
  output logic                 cnt_load,
  output logic [WIDTH-1:0]     cnt_load_val,
  output logic                 cnt_inc,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     step_cnt
);

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    LOAD = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] start_q, end_q;
  logic             dir_q;
  logic             accept;
  logic             step_inc;
  logic [WIDTH-1:0] next_val;

  // Value the counter will hold after this edge if it is allowed to step.
  assign next_val = dir_q ? cnt_out + WIDTH'(1) : cnt_out - WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      start_q  <= '0;
      end_q    <= '0;
      dir_q    <= 1'b0;
      step_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        start_q  <= cmd.cmd_start;
        end_q    <= cmd.cmd_end;
        dir_q    <= cmd.cmd_up;
        step_cnt <= '0;
      end else if (step_inc) begin
        step_cnt <= step_cnt + WIDTH'(1);
      end
    end
  end

  // Default is "hold": the counter has no enable, so it is reloaded with itself.
  always_comb begin
    state_nxt     = state;
    cnt_rst       = 1'b0;
    cnt_load      = 1'b1;
    cnt_load_val  = cnt_out;
    cnt_inc       = 1'b0;
    cmd.cmd_ready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    accept        = 1'b0;
    step_inc      = 1'b0;
    case (state)
      INIT: begin
        cnt_rst      = 1'b1;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        state_nxt    = IDLE;
      end
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        busy         = 1'b1;
        cnt_load_val = start_q;
        if (abort)                 state_nxt = IDLE;
        else if (start_q == end_q) state_nxt = DONE;
        else                       state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (!pause) begin
          cnt_load = 1'b0;
          cnt_inc  = dir_q;
          step_inc = 1'b1;
          if (next_val == end_q) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        cnt_rst      = 1'b1;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        state_nxt    = INIT;
      end
    endcase
  end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer for the team's parallel-load up/down counter (sync active-high reset, parallel_load priority, otherwise counts up or down every clock).
Accepts a sweep command (start, end, direction) over a valid/ready handshake and loads the counter. It then lets it count until it reaches end, and reports completion and the step count.
Because the counter has no enable, the controller holds its value by reloading it with its own output. It also supports pause and abort.

Parameters:
WIDTH, 4, counter width; must match the counted counter's WIDTH.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  command request.
cmd_ready  out  1  controller can accept a command.
cmd_start  in  WIDTH  sweep start value.
cmd_end  in  WIDTH  sweep end value.
cmd_up  in  1  1 = count up, 0 = count down.
pause  in  1  freeze the sweep while high.
abort  in  1  cancel the current sweep.
cnt_out  in  WIDTH  counter's current value.
cnt_rst  out  1  to counter rst (sync, active-high).
cnt_load  out  1  to counter parallel_load.
cnt_load_val  out  WIDTH  to counter parallel_in.
cnt_inc  out  1  to counter inc.
busy  out  1  high in LOAD or RUN.
done  out  1  one-cycle completion pulse.
step_cnt  out  WIDTH  count edges in the last or current sweep.

Behaviour:
- FSM states: INIT, IDLE, LOAD, RUN, DONE. rst=0 forces INIT asynchronously and clears start_q, end_q, dir_q and step_cnt to 0.
- Output decode: cnt_* outputs, cmd_ready, busy and done are combinational from the state, the registers, and pause/abort/cnt_out.
- "Hold" means: cnt_load=1, cnt_load_val=cnt_out, cnt_rst=0, cnt_inc=0.
- INIT: cnt_rst=1, cnt_load=0. Lasts exactly one cycle after rst deasserts, then goes to IDLE. Values while rst=0: cnt_rst=1, cmd_ready=0, busy=0, done=0.
- IDLE: hold; cmd_ready=1. cmd_valid&cmd_ready at a clock edge captures start, end and dir into start_q, end_q, dir_q, clears step_cnt, and goes to LOAD. pause and abort are ignored.
- LOAD (1 cycle): cnt_load=1, cnt_load_val=start_q. Next state: IDLE if abort; else DONE if start_q==end_q; else RUN.
- RUN, abort=1: hold, go to IDLE, no done pulse, step_cnt keeps its value. abort has priority over pause.
- RUN, pause=1: hold. No step_cnt change, no termination check, stays in RUN.
- RUN, otherwise: cnt_load=0, cnt_inc=dir_q, step_cnt+=1.
- RUN termination: if (cnt_out+1 when dir_q, else cnt_out-1), mod 2^WIDTH, equals end_q, go to DONE.
- DONE (1 cycle): hold, done=1, then IDLE.
- Arithmetic: all arithmetic is mod 2^WIDTH, and sweeps wrap through 0 or all-ones. step_cnt = (end-start) mod 2^WIDTH for up sweeps and (start-end) mod 2^WIDTH for down sweeps; maximum 2^WIDTH-1.
- Latency: done is high in the cycle after clock edge number steps+1, counting from the accepting edge (edge 0), when no pause or abort occurs. Counter equals end_q in the DONE cycle.
- cmd_valid outside IDLE is not accepted; the command is not lost and is taken once the FSM is back in IDLE.
- Reset mid-sweep: immediate INIT, counter cleared by cnt_rst on the next clk edges, no done pulse.
- Counter value is never changed except by LOAD, RUN count cycles, or INIT.

Test Plan:
- Up sweep, WIDTH=4, start=3, end=7, up=1 accepted at edge 0 -> counter 3,4,5,6,7 at edges 1-5; done high after edge 5; step_cnt=4; counter stays 7 afterwards.
- Down wrap, start=2, end=13, up=0 -> 2,1,0,15,14,13; step_cnt=5; done once.
- start=end=9 -> LOAD then DONE; done after edge 1; step_cnt=0; no RUN cycles.
- Pause and abort, up 0->15:
  - pause high for 3 cycles when counter=5 -> counter holds at 5 for 3 cycles; done delayed by 3 cycles; final step_cnt=15.
  - abort when counter=8 -> back to IDLE; counter holds at 8; done never pulses.
- Handshake: cmd_valid held high throughout a sweep with new data 4->6 -> second command is accepted only in the IDLE cycle after DONE; cmd_ready=0 during LOAD, RUN and DONE.
- Reset: rst low during RUN at counter=6 -> outputs are at their reset values immediately, counter reads 0 after the next edge, INIT lasts one cycle after release, then IDLE with cmd_ready=1.
